// File: rtl/e_q_pkg.sv
// Phase encoding and E/Q decode shared by the 6809 quadrature clock generator.
package e_q_pkg;

   typedef logic [1:0] phase_t;

   localparam phase_t PH_LOW = 2'd0;
   localparam phase_t PH_Q   = 2'd1;
   localparam phase_t PH_EQ  = 2'd2;
   localparam phase_t PH_E   = 2'd3;

   // Enough to count up to the largest legal MAX_STRETCH.
   localparam int STRETCH_W = 4;

   // Returns {E, Q} for a quarter index.
   function automatic logic [1:0] phase_to_eq(input phase_t ph);
      logic [1:0] eq;
      case (ph)
         PH_LOW:  eq = 2'b00;
         PH_Q:    eq = 2'b01;
         PH_EQ:   eq = 2'b11;
         default: eq = 2'b10;
      endcase
      return eq;
   endfunction

endpackage

// File: rtl/e_q_clk_gen_quarter_timer.sv
// Reloadable quarter-phase down-counter; o_tc flags the last fast-clock cycle of a quarter.
// Latency: o_tc is a decode of the registered count; no backpressure, counts every cycle.
module quarter_timer #(
   parameter int DIV_Q = 25
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_load,
   output logic o_tc
);

   localparam int CW = (DIV_Q > 1) ? $clog2(DIV_Q) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DIV_Q - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign o_tc = (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q - CW'(1);
      if (i_load) begin
         cnt_d = RELOAD;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/e_q_clk_gen.sv
// 6809 E/Q quadrature clock generator with MRDY stretching, park/resume and E-edge strobes.
// Latency: all outputs registered from the next phase; i_enable/i_mrdy act only at quarter ends.
module e_q_clk_gen #(
   parameter int DIV_Q       = 25,
   parameter int MAX_STRETCH = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_enable,
   input  logic       i_mrdy,
   output logic       o_e,
   output logic       o_q,
   output logic [1:0] o_phase,
   output logic       o_e_rise_stb,
   output logic       o_e_fall_stb,
   output logic       o_stretching
);

   import e_q_pkg::*;

   localparam logic [STRETCH_W-1:0] STRETCH_MAX = STRETCH_W'(MAX_STRETCH);

   logic tc;

   phase_t                 phase_q,       phase_d;
   logic [STRETCH_W-1:0]   stretch_cnt_q, stretch_cnt_d;
   logic                   stretching_q,  stretching_d;
   logic                   e_clk_q,       e_clk_d;
   logic                   q_clk_q,       q_clk_d;
   logic                   e_rise_stb_q,  e_rise_stb_d;
   logic                   e_fall_stb_q,  e_fall_stb_d;

   // Every quarter end reloads, including park and stretch holds.
   quarter_timer #(
      .DIV_Q (DIV_Q)
   ) u_quarter_timer (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (tc),
      .o_tc    (tc)
   );

   always_comb begin
      phase_d       = phase_q;
      stretch_cnt_d = stretch_cnt_q;
      stretching_d  = stretching_q;

      if (tc) begin
         case (phase_q)
            PH_LOW: begin
               if (i_enable) begin
                  phase_d = PH_Q;
               end
            end
            PH_Q: begin
               phase_d = PH_EQ;
            end
            PH_EQ: begin
               phase_d = PH_E;
            end
            default: begin
               if (!i_mrdy && (stretch_cnt_q < STRETCH_MAX)) begin
                  stretch_cnt_d = stretch_cnt_q + STRETCH_W'(1);
                  stretching_d  = 1'b1;
               end else begin
                  phase_d       = PH_LOW;
                  stretch_cnt_d = '0;
                  stretching_d  = 1'b0;
               end
            end
         endcase
      end

      {e_clk_d, q_clk_d} = phase_to_eq(phase_d);

      e_rise_stb_d = tc && (phase_q == PH_Q)  && (phase_d == PH_EQ);
      e_fall_stb_d = tc && (phase_q == PH_E)  && (phase_d == PH_LOW);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         phase_q       <= PH_LOW;
         stretch_cnt_q <= '0;
         stretching_q  <= 1'b0;
         e_clk_q       <= 1'b0;
         q_clk_q       <= 1'b0;
         e_rise_stb_q  <= 1'b0;
         e_fall_stb_q  <= 1'b0;
      end else begin
         phase_q       <= phase_d;
         stretch_cnt_q <= stretch_cnt_d;
         stretching_q  <= stretching_d;
         e_clk_q       <= e_clk_d;
         q_clk_q       <= q_clk_d;
         e_rise_stb_q  <= e_rise_stb_d;
         e_fall_stb_q  <= e_fall_stb_d;
      end
   end

   assign o_e          = e_clk_q;
   assign o_q          = q_clk_q;
   assign o_phase      = phase_q;
   assign o_e_rise_stb = e_rise_stb_q;
   assign o_e_fall_stb = e_fall_stb_q;
   assign o_stretching = stretching_q;

endmodule
